lcg_gen: RTL and testbench
==========================

# lcg_gen

Sequential linear congruential generator producing x(n+1) = (a·x(n) + c) mod m from a loaded seed. It emits one value per handshake on a valid/ready output stream. It is the producing end of the LCG flow: it generates the value sequences that the seed-scanning guesser consumes, and it serves both as a bench stimulus source and as an on-chip RNG. The modulo is computed by an iterative shift-subtract unit, so no hardware divider is needed.

## Interface
- WIDTH, 32: operand, seed and output width in bits.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; samples seed, modulus, multiplier and increment, then starts generation.
- seed  in  WIDTH  initial x(0); it need not be less than modulus.
- modulus  in  WIDTH  m.
- multiplier  in  WIDTH  a.
- increment  in  WIDTH  c.
- out_valid  out  1  out_value holds x(n).
- out_ready  in  1  consumer accepts out_value.
- out_value  out  WIDTH  current sequence value.
- out_count  out  WIDTH  number of accepted values; wraps modulo 2^WIDTH.
- busy  out  1  state is not IDLE.
- err  out  1  the last load had modulus == 0.

## Operation
- States: IDLE, MUL, MOD, VALID.
- IDLE, load=1:
  - If modulus==0: set err=1 and stay in IDLE.
  - Otherwise: clear err, latch all four operands into shadow registers, set x=seed, go to MUL.
- MUL: sum = x·a + c, computed at full 2·WIDTH+1 bits with no truncation. Set remainder r=0, bit counter=2·WIDTH. Go to MOD.
- MOD: one restoring step per cycle, from the MSB down.
  - r = (r<<1) | sum[cnt]; if r ≥ m, then r -= m. r is WIDTH+1 bits wide.
  - On the step with cnt==0: set x=out_value=r, go to VALID.
- VALID: out_valid=1 and out_value is held stable.
  - On out_valid && out_ready: increment out_count and go to MUL, which starts x(n+1) from x.
- Priority, highest first:
  1. RST
  2. load, in any state: aborts current work, re-latches operands, restarts. Any pending un-accepted value is dropped and out_count is cleared.
  3. Handshake.
- Input operand pins are ignored except on the load cycle. Later changes to them do not affect a running sequence.
- Emitted values are the same v0, v1, v2… the guesser compares: the first output is (seed·a+c) mod m, not seed itself.
- The generator runs forever until the next load or RST. There is no stop command; the consumer throttles it by holding out_ready low.

## Timing
- Reset values: out_valid=0, out_value=0, out_count=0, busy=0, err=0, state IDLE, shadow registers 0.
- Latency: load sampled at edge k → out_valid high after edge k+2·WIDTH+2 (edge k+66 for WIDTH=32).
- Steady state: handshake at edge j → next out_valid after edge j+2·WIDTH+2.
- out_valid drops on the edge that completes the handshake. It never glitches while out_ready is low.
- out_ready is ignored outside VALID. No combinational path exists from out_ready to out_valid.
- load coincident with a handshake: load wins; out_count becomes 0, not 1.
- err updates only on a load edge and stays set until the next valid load or RST.
- modulus==1: all outputs are 0 at normal latency.

## Structure
- Shared package lcg_pkg:
  - State enum (IDLE/MUL/MOD/VALID).
  - LCG_W default width.
  - Test vector constants: M=993441, A=4001, C=60211, SEED=96, V0..V2.
- One natural sub-module, lcg_mod_seq:
  - Sequential (2W+1)-bit by W-bit remainder unit.
  - Interface: start/done handshake, dividend, divisor, remainder.
  - The guesser can later reuse it in place of its combinational %.
- The top level keeps the FSM, shadow registers, x register and counters.

## Test plan
- Nominal sequence: RST, then load with seed=96, m=993441, a=4001, c=60211, out_ready=1.
  - Required: 444307, 466569, 127141 in order.
  - First out_valid exactly 66 edges after load.
  - out_count reads 3 after the third accept.
- Backpressure: hold out_ready=0 for 20 cycles while out_valid is high.
  - Required: out_value stable and out_valid held.
  - One accept on the first ready cycle; out_count increments once.
- Error case: load with modulus=0.
  - Required: err=1, busy=0, out_valid never rises.
  - A following valid load clears err.
- Abort and degenerate modulus:
  - Load during MOD, about 30 cycles into the first value, with seed=0, m=1, a=5, c=7 → out_value=0, out_count restarted at 0.
  - Load coincident with an accept → out_count=0.
- Reset mid-operation: RST during MOD and during VALID.
  - Required: all outputs return to reset values the next cycle.
  - No out_valid until a new load.
- Model check: random m in [2, 2^16), random a, c, seed; 200 outputs with random out_ready.
  - Required: every output matches a software LCG.
  - Operand pins toggled after load have no effect.

Source files
------------

// File: rtl/lcg_gen_pkg.sv
// Shared types and constants for the LCG generator: FSM encoding, default width,
// and a known-good reference sequence.
package lcg_pkg;

    localparam int LCG_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_MOD,
        ST_VALID
    } lcg_state_t;

    localparam logic [31:0] TV_M    = 32'd993441;
    localparam logic [31:0] TV_A    = 32'd4001;
    localparam logic [31:0] TV_C    = 32'd60211;
    localparam logic [31:0] TV_SEED = 32'd96;
    localparam logic [31:0] TV_V0   = 32'd444307;
    localparam logic [31:0] TV_V1   = 32'd466569;
    localparam logic [31:0] TV_V2   = 32'd127141;

endpackage

// File: rtl/lcg_gen_if.sv
// Output stream of the LCG generator: valid/ready value channel plus accepted-value count.
interface lcg_gen_if #(parameter int WIDTH = 32);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic [WIDTH-1:0] out_count;

    modport master (output out_valid, output out_value, output out_count, input out_ready);
    modport slave  (input out_valid, input out_value, input out_count, output out_ready);
endinterface

// File: rtl/lcg_mod_seq.sv
// Sequential restoring remainder: (2W+1)-bit dividend mod W-bit divisor, one bit per cycle.
// done and remainder are combinational on the final step so the caller can latch them that edge.
module lcg_mod_seq #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start,
    input  logic [2*W:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] remainder
);
    localparam int CW = $clog2(2*W+1);

    logic [2*W:0]  div_q;
    logic [W-1:0]  m_q;
    logic [W-1:0]  r_q;
    logic [CW-1:0] cnt_q;
    logic          running_q;
    logic [W:0]    r_sh;
    logic [W:0]    r_nxt;

    // r_q < m always holds, so the shifted partial remainder fits in W+1 bits
    always_comb begin
        r_sh  = {r_q, div_q[cnt_q]};
        r_nxt = (r_sh >= {1'b0, m_q}) ? (r_sh - {1'b0, m_q}) : r_sh;
    end

    assign done      = running_q && (cnt_q == '0);
    assign remainder = r_nxt[W-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q     <= '0;
            m_q       <= '0;
            r_q       <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else if (start) begin
            div_q     <= dividend;
            m_q       <= divisor;
            r_q       <= '0;
            cnt_q     <= CW'(2*W);
            running_q <= 1'b1;
        end else if (running_q) begin
            r_q   <= r_nxt[W-1:0];
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0)
                running_q <= 1'b0;
        end
    end
endmodule

// File: rtl/lcg_gen.sv
// Linear congruential generator x(n+1) = (a*x(n) + c) mod m, one value per stream handshake.
// state    | meaning
// ST_IDLE  | no operands loaded, or last load had modulus 0
// ST_MUL   | form a*x+c and start the remainder unit
// ST_MOD   | remainder unit stepping; result lands in x on its last step
// ST_VALID | out_value offered, waiting for out_ready
module lcg_gen
    import lcg_pkg::*;
#(
    parameter int WIDTH = LCG_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] increment,
    lcg_gen_if.master        bus,
    output logic             busy,
    output logic             err
);
    localparam int SW = 2*WIDTH + 1;

    lcg_state_t       state_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] x_q;
    logic [SW-1:0]    sum;
    logic             mod_done;
    logic [WIDTH-1:0] mod_rem;

    assign sum  = SW'(x_q) * SW'(a_q) + SW'(c_q);
    assign busy = (state_q != ST_IDLE);

    lcg_mod_seq #(.W(WIDTH)) u_mod (
        .CLK       (CLK),
        .RST       (RST),
        .start     (state_q == ST_MUL),
        .dividend  (sum),
        .divisor   (m_q),
        .done      (mod_done),
        .remainder (mod_rem)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            m_q           <= '0;
            a_q           <= '0;
            c_q           <= '0;
            x_q           <= '0;
            err           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_value <= '0;
            bus.out_count <= '0;
        end else if (load) begin
            // a load always drops pending output and restarts the count
            bus.out_valid <= 1'b0;
            bus.out_count <= '0;
            if (modulus == '0) begin
                err     <= 1'b1;
                state_q <= ST_IDLE;
            end else begin
                err     <= 1'b0;
                m_q     <= modulus;
                a_q     <= multiplier;
                c_q     <= increment;
                x_q     <= seed;
                state_q <= ST_MUL;
            end
        end else begin
            case (state_q)
                ST_MUL: state_q <= ST_MOD;
                ST_MOD: begin
                    if (mod_done) begin
                        x_q           <= mod_rem;
                        bus.out_value <= mod_rem;
                        bus.out_valid <= 1'b1;
                        state_q       <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_count <= bus.out_count + WIDTH'(1);
                        state_q       <= ST_MUL;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcg_gen.sv
// Self-checking bench for lcg_gen: expected values queued at load time, popped on each accept.
module tb_lcg_gen;
    import lcg_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        load;
    logic [31:0] seed, modulus, multiplier, increment;
    logic        busy, err;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    always #5 CLK = ~CLK;

    lcg_gen_if #(.WIDTH(32)) bus ();

    lcg_gen #(.WIDTH(32)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .load       (load),
        .seed       (seed),
        .modulus    (modulus),
        .multiplier (multiplier),
        .increment  (increment),
        .bus        (bus),
        .busy       (busy),
        .err        (err)
    );

    function automatic logic [31:0] lcg_next(input logic [31:0] x, a, c, m);
        logic [64:0] s;
        s = 65'(x) * 65'(a) + 65'(c);
        return 32'(s % 65'(m));
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input logic [31:0] s, m, a, c);
        seed = s; modulus = m; multiplier = a; increment = c;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] s, m, a, c, input int n);
        logic [31:0] x;
        x = s;
        for (int i = 0; i < n; i++) begin
            x = lcg_next(x, a, c, m);
            exp_q.push_back(x);
        end
    endtask

    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0; load = 1'b0; bus.out_ready = 1'b0;
        seed = '0; modulus = '0; multiplier = '0; increment = '0;
        pulse_reset();
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_assert++; if (bus.out_value !== 32'd0) begin n_fail++; $display("FAIL reset_value: got %0d want 0", bus.out_value); end
        n_assert++; if (bus.out_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.out_count); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_nominal();
        int lat, acc;
        logic [31:0] e;
        exp_q.delete();
        exp_q.push_back(TV_V0); exp_q.push_back(TV_V1); exp_q.push_back(TV_V2);
        bus.out_ready = 1'b1;
        do_load(TV_SEED, TV_M, TV_A, TV_C);
        wait_valid(200, lat);
        n_assert++; if (lat != 66) begin n_fail++; $display("FAIL nominal_latency: got %0d want 66", lat); end
        acc = 0;
        for (int cyc = 0; cyc < 400 && acc < 3; cyc++) begin
            if (cyc > 0) tick();
            if (bus.out_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_assert++; if (bus.out_value !== e) begin n_fail++; $display("FAIL nominal_value%0d: got %0d want %0d", acc, bus.out_value, e); end
                acc++;
            end
        end
        n_assert++; if (acc != 3) begin n_fail++; $display("FAIL nominal_timeout: got %0d outputs want 3", acc); end
        tick();
        n_assert++; if (bus.out_count !== 32'd3) begin n_fail++; $display("FAIL nominal_count: got %0d want 3", bus.out_count); end
    endtask

    task automatic test_backpressure();
        int lat, bad;
        logic [31:0] e;
        bus.out_ready = 1'b0;
        exp_q.delete();
        exp_q.push_back(lcg_next(TV_V2, TV_A, TV_C, TV_M));
        wait_valid(200, lat);
        n_assert++; if (lat < 0) begin n_fail++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.out_valid !== 1'b1 || bus.out_value !== exp_q[0]) bad++;
        end
        n_assert++; if (bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
        bus.out_ready = 1'b1;
        e = exp_q.pop_front();
        n_assert++; if (bus.out_value !== e) begin n_fail++; $display("FAIL bp_value: got %0d want %0d", bus.out_value, e); end
        tick();
        bus.out_ready = 1'b0;
        n_assert++; if (bus.out_count !== 32'd4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", bus.out_count); end
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_error();
        int seen;
        pulse_reset();
        bus.out_ready = 1'b1;
        do_load(TV_SEED, 32'd0, TV_A, TV_C);
        n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_busy: got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_assert++; if (seen != 0) begin n_fail++; $display("FAIL err_no_valid: got %0d valid cycles want 0", seen); end
        n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        do_load(TV_SEED, TV_M, TV_A, TV_C);
        n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
        n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL err_restart_busy: got %b want 1", busy); end
    endtask

    task automatic test_abort();
        int lat;
        logic [31:0] e;
        bus.out_ready = 1'b1;
        do_load(TV_SEED, TV_M, TV_A, TV_C);
        wait_valid(200, lat);
        tick();
        repeat (30) tick();
        exp_q.delete();
        push_seq(32'd0, 32'd1, 32'd5, 32'd7, 2);
        do_load(32'd0, 32'd1, 32'd5, 32'd7);
        n_assert++; if (bus.out_count !== 32'd0) begin n_fail++; $display("FAIL abort_count: got %0d want 0", bus.out_count); end
        wait_valid(200, lat);
        n_assert++; if (lat != 66) begin n_fail++; $display("FAIL abort_latency: got %0d want 66", lat); end
        e = exp_q.pop_front();
        n_assert++; if (bus.out_value !== e) begin n_fail++; $display("FAIL abort_value0: got %0d want %0d", bus.out_value, e); end
        tick();
        wait_valid(200, lat);
        e = exp_q.pop_front();
        n_assert++; if (bus.out_value !== e) begin n_fail++; $display("FAIL abort_value1: got %0d want %0d", bus.out_value, e); end
        n_assert++; if (bus.out_count !== 32'd1) begin n_fail++; $display("FAIL abort_count1: got %0d want 1", bus.out_count); end
    endtask

    task automatic test_load_on_accept();
        int lat;
        logic [31:0] e;
        bus.out_ready = 1'b0;
        do_load(TV_SEED, TV_M, TV_A, TV_C);
        wait_valid(200, lat);
        exp_q.delete();
        exp_q.push_back(TV_V0);
        bus.out_ready = 1'b1;
        do_load(TV_SEED, TV_M, TV_A, TV_C);
        bus.out_ready = 1'b0;
        n_assert++; if (bus.out_count !== 32'd0) begin n_fail++; $display("FAIL loadacc_count: got %0d want 0", bus.out_count); end
        n_assert++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL loadacc_valid: got %b want 0", bus.out_valid); end
        wait_valid(200, lat);
        n_assert++; if (lat != 66) begin n_fail++; $display("FAIL loadacc_latency: got %0d want 66", lat); end
        e = exp_q.pop_front();
        n_assert++; if (bus.out_value !== e) begin n_fail++; $display("FAIL loadacc_value: got %0d want %0d", bus.out_value, e); end
    endtask

    task automatic test_reset_mid();
        int lat, seen;
        bus.out_ready = 1'b1;
        do_load(TV_SEED, TV_M, TV_A, TV_C);
        wait_valid(200, lat);
        tick();
        repeat (30) tick();
        RST = 1'b1; tick(); RST = 1'b0;
        n_assert++; if (bus.out_value !== 32'd0 || bus.out_count !== 32'd0 || bus.out_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mod: got value=%0d count=%0d valid=%b busy=%b err=%b want all 0", bus.out_value, bus.out_count, bus.out_valid, busy, err);
        end
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen++;
        end
        n_assert++; if (seen != 0) begin n_fail++; $display("FAIL rst_no_valid: got %0d valid cycles want 0", seen); end
        bus.out_ready = 1'b0;
        do_load(TV_SEED, TV_M, TV_A, TV_C);
        wait_valid(200, lat);
        RST = 1'b1; tick(); RST = 1'b0;
        n_assert++; if (bus.out_value !== 32'd0 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid_state: got value=%0d valid=%b busy=%b want all 0", bus.out_value, bus.out_valid, busy);
        end
    endtask

    task automatic test_model();
        logic [31:0] s, m, a, c, e;
        int acc;
        pulse_reset();
        m = 32'($urandom_range(2, 65535));
        a = $urandom; c = $urandom; s = $urandom;
        exp_q.delete();
        push_seq(s, m, a, c, 200);
        bus.out_ready = 1'b0;
        do_load(s, m, a, c);
        acc = 0;
        for (int cyc = 0; cyc < 40000 && acc < 200; cyc++) begin
            tick();
            seed = $urandom; modulus = $urandom; multiplier = $urandom; increment = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_assert++; if (bus.out_value !== e) begin n_fail++; $display("FAIL model_value%0d: got %0d want %0d", acc, bus.out_value, e); end
                acc++;
            end
        end
        n_assert++; if (acc != 200) begin n_fail++; $display("FAIL model_timeout: got %0d outputs want 200", acc); end
        tick();
        bus.out_ready = 1'b0;
        n_assert++; if (bus.out_count !== 32'd200) begin n_fail++; $display("FAIL model_count: got %0d want 200", bus.out_count); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_error();
        test_abort();
        test_load_on_accept();
        test_reset_mid();
        test_model();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
